// File: rtl/jogo_pkg.sv
// Shared types and constants for the move detector (state encoding, debug codes, defaults).
package jogo_pkg;

    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 8;
    localparam int unsigned N_BOTOES               = 4;
    localparam int unsigned ESTADO_W               = 3;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO        = 3'd0,
        FILTRA        = 3'd1,
        REGISTRA      = 3'd2,
        ESPERA_SOLTAR = 3'd3
    } estado_t;

    localparam logic [ESTADO_W-1:0] DB_OCIOSO        = 3'd0;
    localparam logic [ESTADO_W-1:0] DB_FILTRA        = 3'd1;
    localparam logic [ESTADO_W-1:0] DB_REGISTRA      = 3'd2;
    localparam logic [ESTADO_W-1:0] DB_ESPERA_SOLTAR = 3'd3;

    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
    endfunction

    function automatic logic [ESTADO_W-1:0] estado_para_db(input estado_t e);
        case (e)
            OCIOSO:        return DB_OCIOSO;
            FILTRA:        return DB_FILTRA;
            REGISTRA:      return DB_REGISTRA;
            ESPERA_SOLTAR: return DB_ESPERA_SOLTAR;
            default:       return DB_OCIOSO;
        endcase
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, asynchronous active-high reset.
module sincronizador_2ff #(
    parameter int unsigned LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the colour buttons and reports one accepted one-hot move per press.
// Optional debug ports db_estado/db_contador are built when DETECTOR_JOGADA_DB_EN is defined.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    input  logic                limpa,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                jogada_invalida
`ifdef DETECTOR_JOGADA_DB_EN
    ,
    output logic [ESTADO_W-1:0]                    db_estado,
    output logic [$clog2(DEBOUNCE_CICLOS+1)-1:0]   db_contador
`endif
);

    localparam int unsigned        CONT_W   = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CONT_W-1:0]  CONT_FIM = CONT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sinc;
    estado_t             estado, estado_n;
    logic [N_BOTOES-1:0] candidato, candidato_n;
    logic [CONT_W-1:0]   contador, contador_n;
    logic [N_BOTOES-1:0] jogada_n;
    logic                tem_jogada_n, jogada_invalida_n;

    sincronizador_2ff #(
        .LARGURA (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sinc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado          <= OCIOSO;
            candidato       <= '0;
            contador        <= '0;
            jogada          <= '0;
            tem_jogada      <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            estado          <= estado_n;
            candidato       <= candidato_n;
            contador        <= contador_n;
            jogada          <= jogada_n;
            tem_jogada      <= tem_jogada_n;
            jogada_invalida <= jogada_invalida_n;
        end
    end

    // Counter saturates at CONT_FIM: every path reaching it leaves the state or clears it.
    always_comb begin
        estado_n          = estado;
        candidato_n       = candidato;
        contador_n        = contador;
        jogada_n          = limpa ? '0 : jogada;
        tem_jogada_n      = 1'b0;
        jogada_invalida_n = 1'b0;

        case (estado)
            OCIOSO: begin
                if (habilita && (sinc != '0)) begin
                    estado_n    = FILTRA;
                    candidato_n = sinc;
                    contador_n  = '0;
                end
            end
            FILTRA: begin
                if (!habilita || (sinc == '0)) begin
                    estado_n   = OCIOSO;
                    contador_n = '0;
                end else if (sinc != candidato) begin
                    candidato_n = sinc;
                    contador_n  = '0;
                end else if (contador == CONT_FIM) begin
                    contador_n = '0;
                    if (eh_one_hot(candidato)) begin
                        estado_n = REGISTRA;
                    end else begin
                        jogada_invalida_n = 1'b1;
                        estado_n          = ESPERA_SOLTAR;
                    end
                end else begin
                    contador_n = contador + CONT_W'(1);
                end
            end
            REGISTRA: begin
                tem_jogada_n = 1'b1;
                if (!limpa) begin
                    jogada_n = candidato;
                end
                estado_n   = ESPERA_SOLTAR;
                contador_n = '0;
            end
            ESPERA_SOLTAR: begin
                if (sinc != '0) begin
                    contador_n = '0;
                end else if (contador == CONT_FIM) begin
                    estado_n   = OCIOSO;
                    contador_n = '0;
                end else begin
                    contador_n = contador + CONT_W'(1);
                end
            end
            default: begin
                estado_n   = OCIOSO;
                contador_n = '0;
            end
        endcase
    end

`ifdef DETECTOR_JOGADA_DB_EN
    assign db_estado   = estado_para_db(estado);
    assign db_contador = contador;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: directed scenarios plus random stimulus vs. a run-length model.
module tb_detector_jogada;
    import jogo_pkg::*;

    localparam int unsigned D = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       limpa;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_invalida;

    always #5 clock = ~clock;

    detector_jogada #(
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .limpa           (limpa),
        .jogada          (jogada),
        .tem_jogada      (tem_jogada),
        .jogada_invalida (jogada_invalida)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: press accepted after D+1 equal synchronized samples, release after D zero samples.
    typedef enum int {M_IDLE, M_FILT, M_ACCEPT, M_RELEASE} mode_t;
    mode_t      m_mode;
    logic [3:0] m_s1, m_s2, m_val, m_jog;
    int         m_run;
    bit         m_tem, m_inv;

    int tem_cnt, inv_cnt, cyc, pulse_cyc;

    function automatic bit one_hot(input logic [3:0] v);
        int ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(v[i]);
        return ones == 1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_s1 = '0; m_s2 = '0; m_val = '0; m_jog = '0;
        m_run = 0; m_tem = 0; m_inv = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        s = m_s2;
        m_tem = 0;
        m_inv = 0;
        if (limpa) m_jog = '0;
        case (m_mode)
            M_IDLE: if (habilita && s != 0) begin
                m_mode = M_FILT; m_val = s; m_run = 1;
            end
            M_FILT: begin
                if (!habilita || s == 0) m_mode = M_IDLE;
                else if (s != m_val) begin m_val = s; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run == D + 1) begin
                        if (one_hot(m_val)) m_mode = M_ACCEPT;
                        else begin m_inv = 1; m_mode = M_RELEASE; m_run = 0; end
                    end
                end
            end
            M_ACCEPT: begin
                m_tem = 1;
                if (!limpa) m_jog = m_val;
                m_mode = M_RELEASE;
                m_run = 0;
            end
            M_RELEASE: begin
                if (s == 0) begin
                    m_run++;
                    if (m_run == D) m_mode = M_IDLE;
                end else m_run = 0;
            end
        endcase
        m_s2 = m_s1;
        m_s1 = botoes;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        cyc++;
        #1;
        chk_eq("jogada", 8'(jogada), 8'(m_jog));
        chk_eq("tem_jogada", 8'(tem_jogada), 8'(m_tem));
        chk_eq("jogada_invalida", 8'(jogada_invalida), 8'(m_inv));
        chk_eq("exclusive", 8'(tem_jogada & jogada_invalida), 8'd0);
        if (tem_jogada) begin tem_cnt++; pulse_cyc = cyc; end
        if (jogada_invalida) inv_cnt++;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        botoes = v;
        repeat (n) step();
    endtask

    task automatic clr_counts();
        tem_cnt = 0; inv_cnt = 0; cyc = 0; pulse_cyc = -1;
    endtask

    initial begin
        reset = 1'b1; botoes = '0; habilita = 1'b0; limpa = 1'b0;
        model_reset();
        clr_counts();
        step(); step();
        chk_eq("reset_jogada", 8'(jogada), 8'd0);
        chk_eq("reset_tem", 8'(tem_jogada), 8'd0);
        reset = 1'b0;
        habilita = 1'b1;
        step();

        // Single clean press: pulse visible after the 12th edge that samples it.
        clr_counts();
        hold(4'b0001, 20);
        chk_eq("press_pulses", 8'(tem_cnt), 8'd1);
        chk_eq("press_latency", 8'(pulse_cyc), 8'd12);
        chk_eq("press_jogada", 8'(jogada), 8'h1);
        hold(4'b0000, 12);
        chk_eq("press_no_more", 8'(tem_cnt), 8'd1);

        // Glitchy press then stable.
        clr_counts();
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 4'b0010 : 4'b0000, 3);
        chk_eq("glitch_quiet", 8'(tem_cnt), 8'd0);
        hold(4'b0010, 20);
        hold(4'b0000, 12);
        chk_eq("glitch_pulses", 8'(tem_cnt), 8'd1);
        chk_eq("glitch_jogada", 8'(jogada), 8'h2);

        // Multi-button press is rejected.
        clr_counts();
        hold(4'b0110, 20);
        hold(4'b0000, 12);
        chk_eq("multi_inv", 8'(inv_cnt), 8'd1);
        chk_eq("multi_tem", 8'(tem_cnt), 8'd0);
        chk_eq("multi_jogada", 8'(jogada), 8'h2);

        // Short release: second press swallowed.
        clr_counts();
        hold(4'b0100, 15);
        hold(4'b0000, 3);
        hold(4'b1000, 20);
        hold(4'b0000, 12);
        chk_eq("short_release", 8'(tem_cnt), 8'd1);
        chk_eq("short_jogada", 8'(jogada), 8'h4);

        // Full release: both presses accepted.
        clr_counts();
        hold(4'b0100, 15);
        hold(4'b0000, 10);
        hold(4'b1000, 15);
        hold(4'b0000, 12);
        chk_eq("long_release", 8'(tem_cnt), 8'd2);
        chk_eq("long_jogada", 8'(jogada), 8'h8);

        // Disabled: no move.
        clr_counts();
        habilita = 1'b0;
        hold(4'b0001, 20);
        chk_eq("disabled", 8'(tem_cnt), 8'd0);
        hold(4'b0000, 4);
        habilita = 1'b1;

        // limpa coincident with the load cycle.
        begin
            bit found = 0;
            botoes = 4'b0001;
            for (int i = 0; i < 30 && !found; i++) begin
                step();
                if (m_mode == M_ACCEPT) found = 1;
            end
            chk_eq("limpa_reach", 8'(found), 8'd1);
            limpa = 1'b1;
            step();
            limpa = 1'b0;
            chk_eq("limpa_tem", 8'(tem_jogada), 8'd1);
            chk_eq("limpa_jogada", 8'(jogada), 8'h0);
            hold(4'b0000, 12);
        end

        // Reset in the middle of filtering.
        hold(4'b1000, 20);
        hold(4'b0000, 12);
        clr_counts();
        hold(4'b0100, 6);
        reset = 1'b1;
        #1;
        model_reset();
        chk_eq("rst_mid_jogada", 8'(jogada), 8'd0);
        chk_eq("rst_mid_tem", 8'(tem_jogada), 8'd0);
        chk_eq("rst_mid_inv", 8'(jogada_invalida), 8'd0);
        step(); step();
        reset = 1'b0;
        hold(4'b0100, 20);
        hold(4'b0000, 12);
        chk_eq("rst_mid_pulses", 8'(tem_cnt), 8'd1);
        chk_eq("rst_mid_final", 8'(jogada), 8'h4);

        // Random segments.
        repeat (150) begin
            int  len;
            int  kind;
            bit  glitch;
            len    = int'($urandom_range(1, 25));
            kind   = int'($urandom_range(0, 9));
            glitch = (kind == 9);
            if (kind <= 2)      botoes = 4'b0000;
            else if (kind <= 6) botoes = 4'(1 << $urandom_range(0, 3));
            else                botoes = 4'($urandom_range(1, 15));
            habilita = ($urandom_range(0, 7) != 0);
            repeat (len) begin
                limpa = ($urandom_range(0, 29) == 0);
                if (glitch) botoes = 4'($urandom);
                step();
            end
        end
        limpa = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CICLOS, default 8, meaning consecutive stable cycles needed to accept a press or a release (legal range 2..255).
REQ-002 The block SHALL have port clock, input, 1, single clock for all state.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port botoes, input, 4, raw asynchronous push-buttons, one bit per colour.
REQ-005 The block SHALL have port habilita, input, 1, high while the game FSM awaits a move.
REQ-006 The block SHALL have port limpa, input, 1, synchronous clear of the stored move.
REQ-007 The block SHALL have port jogada, output, 4, registered last valid one-hot move.
REQ-008 The block SHALL have port tem_jogada, output, 1, one-cycle pulse when a valid move is accepted.
REQ-009 The block SHALL have port jogada_invalida, output, 1, one-cycle pulse when a stable multi-button press is rejected.

Function
REQ-010 The block SHALL pass botoes through a two-flop synchronizer; all other logic SHALL use only the synchronized value (sinc).
REQ-011 The FSM SHALL have states OCIOSO, FILTRA, REGISTRA and ESPERA_SOLTAR.
REQ-012 In OCIOSO with habilita=1 and sinc!=0, the FSM SHALL latch sinc as candidate, clear the counter and go to FILTRA; otherwise it SHALL stay in OCIOSO.
REQ-013 In FILTRA, each cycle with sinc==candidate SHALL increment the counter; sinc!=candidate and nonzero SHALL relatch the candidate and clear the counter; sinc==0 SHALL return to OCIOSO.
REQ-014 When the counter reaches DEBOUNCE_CICLOS-1 with sinc==candidate, the FSM SHALL go to REGISTRA if the candidate is one-hot, else pulse jogada_invalida for one cycle and go to ESPERA_SOLTAR.
REQ-015 In REGISTRA, the block SHALL load jogada with the candidate, assert tem_jogada for exactly that one cycle, and go to ESPERA_SOLTAR.
REQ-016 In ESPERA_SOLTAR, the FSM SHALL return to OCIOSO only after sinc==0 for DEBOUNCE_CICLOS consecutive cycles; any nonzero sinc SHALL clear the counter.
REQ-017 Deasserting habilita in FILTRA SHALL return the FSM to OCIOSO with no pulse; habilita SHALL be ignored in REGISTRA and ESPERA_SOLTAR.
REQ-018 Holding a button SHALL yield exactly one tem_jogada; a new press SHALL be accepted only after the release is debounced.
REQ-019 limpa SHALL clear jogada to 0 on the next edge, and SHALL take priority over a simultaneous REGISTRA load, although tem_jogada still pulses.
REQ-020 The counter width SHALL be $clog2(DEBOUNCE_CICLOS+1) bits, and the counter SHALL never wrap.
REQ-021 tem_jogada and jogada_invalida SHALL never be high in the same cycle.

Reset
REQ-022 On reset, the block SHALL immediately set the FSM to OCIOSO and clear the synchronizer, candidate, counter, jogada, tem_jogada and jogada_invalida to 0; reset mid-press SHALL discard the press.

Configuration
REQ-023 With macro DETECTOR_JOGADA_DB_EN defined, the block SHALL add output db_estado (3 bits: OCIOSO=0, FILTRA=1, REGISTRA=2, ESPERA_SOLTAR=3) and output db_contador (counter value); without the macro, these ports and their logic SHALL be absent, and function SHALL be otherwise identical.

Structure
REQ-024 Package jogo_pkg SHALL hold the state enum typedef, the db_estado encodings and the DEBOUNCE_CICLOS default constant.
REQ-025 The synchronizer SHALL be the sub-module sincronizador_2ff (parameterised width, async reset).

Verification
REQ-026 Reset, then botoes=0001 with habilita=1 held 20 cycles (DEBOUNCE_CICLOS=8) -> one tem_jogada pulse 11 edges after first sample, jogada=0001, then no further pulse.
REQ-027 Glitchy press: botoes=0010 toggled every 3 cycles for 30 cycles, then held -> no pulse during toggling, exactly one pulse after it stabilises.
REQ-028 botoes=0110 held 20 cycles -> one jogada_invalida pulse, no tem_jogada, jogada unchanged.
REQ-029 Press 0100 and release for 3 cycles, then press 1000 -> the second press is ignored until 8 zero cycles elapse; the sequence 0100, release(10), 1000 yields two pulses.
REQ-030 habilita=0 with botoes=0001 held -> no pulse; limpa during REGISTRA -> tem_jogada pulses and jogada reads 0.
REQ-031 Reset asserted mid-FILTRA -> outputs 0 immediately; after reset is released with the button still held -> a fresh debounce, then one pulse.
